rom_arb_2ch: RTL and testbench

- Arbiter sharing the single wave ROM (1000 × 8 bit: sine at 0–499, triangle at 500–999) between two wave-channel address generators.
- Lets two DA channels run from one ROM instance, e.g. sine plus phase-shifted triangle.
- Sits between the per-channel address generators and the ROM.
- Tracks every outstanding read through the ROM latency and returns data to the channel that requested it.

---
 rtl/rom_arb_pkg.sv | 17 +
 rtl/rom_arb_tag_pipe.sv | 31 +++
 rtl/rom_arb_2ch.sv | 97 +++++++++
 tb/tb_rom_arb_2ch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types for the two-channel wave ROM arbiter.
package rom_arb_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 8;

   typedef logic ch_id_t;

   typedef struct packed {
      logic   valid;
      ch_id_t id;
   } arb_tag_t;

   localparam ch_id_t CH0 = 1'b0;
   localparam ch_id_t CH1 = 1'b1;

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// Tag shift register that follows each ROM read through the ROM latency.
// tag_cap is the stage whose data is on rom_rdata this cycle;
// tag_out is the final stage and marks the cycle the channel sees rvalid.
module rom_arb_tag_pipe
   import rom_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   input  arb_tag_t tag_in,
   output arb_tag_t tag_cap,
   output arb_tag_t tag_out
);

   arb_tag_t stage_q [DEPTH];

   // Shift one stage per clock; reset discards every in-flight tag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tag_cap = stage_q[DEPTH-2];
   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/rom_arb_2ch.sv
// Two-channel arbiter in front of the shared wave ROM.
// Default build: round-robin on ties, ch0 wins the first tie after reset.
// Build option ROM_ARB_CH0_PRIO_EN: fixed priority, ch0 always wins a tie.
// The registered rom_addr acts as the ROM input register; rom_rdata carries
// the data for a given rom_addr ROM_LAT-1 cycles after rom_addr shows it, so
// a grant in cycle N produces rvalid in cycle N+ROM_LAT+1.
module rom_arb_2ch
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ROM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ch0_req,
   input  logic [ADDR_W-1:0] ch0_addr,
   output logic              ch0_gnt,
   output logic [DATA_W-1:0] ch0_rdata,
   output logic              ch0_rvalid,
   input  logic              ch1_req,
   input  logic [ADDR_W-1:0] ch1_addr,
   output logic              ch1_gnt,
   output logic [DATA_W-1:0] ch1_rdata,
   output logic              ch1_rvalid,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_rdata
);

   arb_tag_t tag_in;
   arb_tag_t tag_cap;
   arb_tag_t tag_out;

`ifndef ROM_ARB_CH0_PRIO_EN
   ch_id_t last_q;

   // Remember the most recent winner so a tie goes to the other channel.
   always_ff @(posedge clk) begin
      if (!rst_n)       last_q <= CH1;
      else if (ch0_gnt) last_q <= CH0;
      else if (ch1_gnt) last_q <= CH1;
   end
`endif

   // Single grant per cycle, straight from the request lines.
   always_comb begin
      ch0_gnt = 1'b0;
      ch1_gnt = 1'b0;
`ifdef ROM_ARB_CH0_PRIO_EN
      ch0_gnt = ch0_req;
      ch1_gnt = ch1_req & ~ch0_req;
`else
      if (ch0_req && ch1_req) begin
         ch0_gnt = (last_q == CH1);
         ch1_gnt = (last_q == CH0);
      end else begin
         ch0_gnt = ch0_req;
         ch1_gnt = ch1_req;
      end
`endif
   end

   // Launch the winner's address into the ROM; hold it when idle.
   always_ff @(posedge clk) begin
      if (!rst_n)       rom_addr <= '0;
      else if (ch0_gnt) rom_addr <= ch0_addr;
      else if (ch1_gnt) rom_addr <= ch1_addr;
   end

   assign tag_in.valid = ch0_gnt | ch1_gnt;
   assign tag_in.id    = ch1_gnt ? CH1 : CH0;

   rom_arb_tag_pipe #(
      .DEPTH (ROM_LAT + 1)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (tag_in),
      .tag_cap (tag_cap),
      .tag_out (tag_out)
   );

   // Steer returning ROM data into the requesting channel's holding register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ch0_rdata <= '0;
         ch1_rdata <= '0;
      end else if (tag_cap.valid) begin
         if (tag_cap.id == CH0) ch0_rdata <= rom_rdata;
         else                   ch1_rdata <= rom_rdata;
      end
   end

   assign ch0_rvalid = tag_out.valid & (tag_out.id == CH0);
   assign ch1_rvalid = tag_out.valid & (tag_out.id == CH1);

endmodule

// File: tb/tb_rom_arb_2ch.sv
module tb_rom_arb_2ch;

   localparam int AW  = 10;
   localparam int DW  = 8;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ch0_req = 1'b0, ch1_req = 1'b0;
   logic [AW-1:0] ch0_addr = '0, ch1_addr = '0;
   logic          ch0_gnt, ch1_gnt, ch0_rvalid, ch1_rvalid;
   logic [DW-1:0] ch0_rdata, ch1_rdata;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_rdata;

   always #5 clk = ~clk;

   // ROM whose input register is the arbiter's rom_addr; contents = addr[7:0].
   assign rom_rdata = rom_addr[DW-1:0];

   rom_arb_2ch #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ch0_req    (ch0_req),
      .ch0_addr   (ch0_addr),
      .ch0_gnt    (ch0_gnt),
      .ch0_rdata  (ch0_rdata),
      .ch0_rvalid (ch0_rvalid),
      .ch1_req    (ch1_req),
      .ch1_addr   (ch1_addr),
      .ch1_gnt    (ch1_gnt),
      .ch1_rdata  (ch1_rdata),
      .ch1_rvalid (ch1_rvalid),
      .rom_addr   (rom_addr),
      .rom_rdata  (rom_rdata)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: who last won, what is in flight and when it is due.
   int            cyc = 0;
   int            m_last = 1;
   logic [AW-1:0] m_raddr = '0;
   logic [DW-1:0] m_rd [2];
   int            q_due [$];
   int            q_ch  [$];
   logic [DW-1:0] q_dat [$];
   int            n_ret [2];

   task automatic model_reset();
      m_last  = 1;
      m_raddr = '0;
      m_rd[0] = '0;
      m_rd[1] = '0;
      q_due.delete();
      q_ch.delete();
      q_dat.delete();
   endtask

   task automatic do_reset();
      ch0_req = 1'b0;
      ch1_req = 1'b0;
      rst_n   = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      rst_n = 1'b1;
      model_reset();
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rdata0", ch0_rdata, 0);
      chk("rst_rdata1", ch1_rdata, 0);
      chk("rst_rvalid0", ch0_rvalid, 0);
      chk("rst_rvalid1", ch1_rvalid, 0);
   endtask

   // Observe one cycle with the inputs currently driven, then advance the model.
   task automatic run_cycle();
      bit            e0, e1, rv0, rv1;
      logic [AW-1:0] ga;
      int            gid;
      rv0 = 0;
      rv1 = 0;
      ga  = '0;
      gid = 0;
      @(negedge clk);
      if (ch0_req && ch1_req) begin
`ifdef ROM_ARB_CH0_PRIO_EN
         e0 = 1;
         e1 = 0;
`else
         e0 = (m_last == 1);
         e1 = !e0;
`endif
      end else begin
         e0 = ch0_req;
         e1 = ch1_req;
      end
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         if (q_ch[0] == 0) rv0 = 1;
         else              rv1 = 1;
         m_rd[q_ch[0]] = q_dat[0];
         n_ret[q_ch[0]]++;
         void'(q_due.pop_front());
         void'(q_ch.pop_front());
         void'(q_dat.pop_front());
      end
      chk("gnt0", ch0_gnt, e0);
      chk("gnt1", ch1_gnt, e1);
      chk("rvalid0", ch0_rvalid, rv0);
      chk("rvalid1", ch1_rvalid, rv1);
      chk("rdata0", ch0_rdata, m_rd[0]);
      chk("rdata1", ch1_rdata, m_rd[1]);
      chk("rom_addr", rom_addr, m_raddr);
      if (e0) begin ga = ch0_addr; gid = 0; end
      else if (e1) begin ga = ch1_addr; gid = 1; end
      @(posedge clk);
      if (e0 || e1) begin
         m_raddr = ga;
         m_last  = gid;
         q_due.push_back(cyc + LAT + 1);
         q_ch.push_back(gid);
         q_dat.push_back(ga[DW-1:0]);
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      ch0_req = 1'b0;
      ch1_req = 1'b0;
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   initial begin
      n_ret[0] = 0;
      n_ret[1] = 0;
      model_reset();

      // Lone ch0 read of address 7.
      do_reset();
      ch0_req = 1'b1; ch0_addr = 10'd7;
      run_cycle();
      idle(4);
      chk("s1_ret0", n_ret[0], 1);
      chk("s1_data0", ch0_rdata, 8'h07);
      chk("s1_ret1", n_ret[1], 0);

      // Both held: alternation starting with ch0.
      do_reset();
      n_ret[0] = 0; n_ret[1] = 0;
      ch0_req = 1'b1; ch0_addr = 10'd10;
      ch1_req = 1'b1; ch1_addr = 10'd510;
      for (int i = 0; i < 8; i++) run_cycle();
      idle(3);
      chk("s2_ret0", n_ret[0], 4);
      chk("s2_ret1", n_ret[1], 4);
`ifndef ROM_ARB_CH0_PRIO_EN
      chk("s2_data1", ch1_rdata, 8'hFE);
`endif

      // ch1 streaming 500..504 back-to-back.
      n_ret[0] = 0; n_ret[1] = 0;
      ch1_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ch1_addr = 10'(500 + i);
         run_cycle();
      end
      idle(3);
      chk("s3_ret1", n_ret[1], 5);
      chk("s3_data1", ch1_rdata, 8'hF8);

      // Two grants in flight, then reset; next tie must go to ch0.
      n_ret[0] = 0; n_ret[1] = 0;
      ch0_req = 1'b1; ch0_addr = 10'd3;
      run_cycle();
      ch0_req = 1'b0;
      ch1_req = 1'b1; ch1_addr = 10'd600;
      run_cycle();
      do_reset();
      ch0_req = 1'b1; ch0_addr = 10'd20;
      ch1_req = 1'b1; ch1_addr = 10'd21;
      run_cycle();
      idle(3);
      chk("s4_ret0", n_ret[0], 1);
      chk("s4_ret1", n_ret[1], 0);

      // ch0 pulses once while losing a tie, then drops.
      n_ret[0] = 0; n_ret[1] = 0;
      ch0_req = 1'b1; ch0_addr = 10'd1;
      ch1_req = 1'b0;
      run_cycle();
      ch0_addr = 10'd2;
      ch1_req = 1'b1; ch1_addr = 10'd700;
      run_cycle();
      ch0_req = 1'b0;
      run_cycle();
      run_cycle();
      idle(3);
`ifdef ROM_ARB_CH0_PRIO_EN
      chk("s5_ret0", n_ret[0], 2);
`else
      chk("s5_ret0", n_ret[0], 1);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset();
         end else begin
            ch0_req  = ($urandom_range(0, 3) != 0);
            ch1_req  = ($urandom_range(0, 3) != 0);
            ch0_addr = AW'($urandom_range(0, 999));
            ch1_addr = AW'($urandom_range(0, 999));
            run_cycle();
         end
      end
      idle(4);
      chk("drain_empty", q_due.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
